simple_length_header_inserter: RTL
==================================

// Module: simple_length_header_inserter
// PURPOSE
//  Transmit-side partner of the length-stripping tlast injector. Accepts tlast-framed AXI-Stream
//  packets and re-emits each one as a 1-byte length header followed by the payload.
//  The link to the far end therefore needs no tlast sideband.
//  The block stores and forwards each packet, because the length is known only when tlast arrives.
// PARAMETERS
//  AXIS_BYTES      1    data width in bytes; header occupies tdata[7:0], upper bits zero
//  BUF_DEPTH       256  payload buffer entries; power of 2, >= 255 so a max-size packet always fits
//  LEN_FIFO_DEPTH  4    committed-packet length entries; power of 2, >= 2
// PORTS
//  clk            in   1               single clock domain
//  sresetn        in   1               synchronous reset, active low
//  axis_i_tready  out  1               input may be accepted
//  axis_i_tvalid  in   1               input beat valid
//  axis_i_tlast   in   1               last beat of input packet
//  axis_i_tdata   in   AXIS_BYTES*8    input payload
//  axis_o_tready  in   1               downstream ready
//  axis_o_tvalid  out  1               output beat valid
//  axis_o_tlast   out  1               last payload beat of a framed packet (never set on header)
//  axis_o_tdata   out  AXIS_BYTES*8    header byte or payload
// BEHAVIOUR
//  - Reset: axis_i_tready=0, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0.
//    Both FIFOs are emptied and partial packets are discarded.
//    Reset applied mid-packet has the same effect.
//  - Header value N (1..255) = number of payload beats that follow. N=0 is never emitted.
//  - Input side:
//    - axis_i_tready = !buf_full && !len_full. Both are registered, so there is no comb path from output.
//    - Each accepted beat is written to the payload buffer and increments in_cnt (8 bit).
//    - When the accepted beat has tlast=1, or in_cnt+1 == 255, the block pushes in_cnt+1 to the length FIFO and clears in_cnt.
//    - A packet longer than 255 beats is therefore split into 255-beat segments plus a remainder.
//    - The forced split has priority. A tlast arriving on beat 255 yields a single push.
//  - Output FSM (enum in package):
//    - SM_HEADER: axis_o_tvalid = !len_empty, tdata = len FIFO head, tlast=0.
//      On handshake: pop the length into out_cnt, then go to SM_DATA.
//    - SM_DATA: axis_o_tvalid = !buf_empty, tdata = buffer head, tlast = (out_cnt==1).
//      On handshake: pop the buffer and decrement out_cnt.
//      When out_cnt==1 at the handshake, go to SM_HEADER.
//  - Only committed packets are emitted; uncommitted tail beats are never read.
//  - Latency: the header is valid on the 2nd cycle after the tlast beat is accepted (FIFO push is registered).
//    Payload is back-to-back after that if axis_o_tready=1.
//  - Output beats hold stable under backpressure (AXIS rule: tvalid/tdata must not change until tready).
//  - Simultaneous push and pop on either FIFO in one cycle are legal.
//    Occupancy is unchanged; full and empty flags stay correct.
//  - in_cnt and out_cnt are 8-bit and must never wrap. The 255 split guarantees this.
// STRUCTURE
//  - Package simple_length_pkg:
//    - COUNT_BYTES=1
//    - MAX_PKT_LEN=255
//    - typedef enum logic {SM_HEADER, SM_DATA} len_tx_state_t
//  - Sub-module simple_axis_fifo #(WIDTH, DEPTH): synchronous show-ahead FIFO with full/empty flags.
//    - One instance is the payload buffer; one is the length FIFO.
//    - Top level holds in_cnt, out_cnt and the output FSM.
// TESTING
//  1. In A1,A2,A3(tlast), out_tready=1 -> out 03,A1,A2,A3(tlast); header 2 cycles after A3 accepted.
//  2. Single beat 5A(tlast) -> out 01,5A(tlast); tlast=0 on header beat.
//  3. 300-beat packet, tlast on beat 300 -> FF + 255 beats (tlast on 255th), then 2D + 45 beats (tlast).
//  4. 20 random packets (len 1..40), random 50% axis_o_tready -> byte-exact headers and payload.
//     Also check tvalid/tdata held stable under backpressure.
//  5. out_tready=0, feed 4 single-beat packets -> axis_i_tready=0 after 4th commit.
//     Release out_tready -> all 4 frames emitted in order.
//  6. sresetn low for 1 cycle after 2 beats of a 5-beat packet -> all outputs 0 next cycle.
//     A following packet B0(tlast) yields exactly 01,B0(tlast).

Source files
------------

// File: rtl/simple_length_header_inserter_pkg.sv
// Shared constants and types for the length-header inserter.
//   COUNT_BYTES    width of the length header in bytes
//   MAX_PKT_LEN    largest length a single header can carry
//   len_tx_state_t output framing FSM states
package simple_length_pkg;
  localparam int COUNT_BYTES = 1;
  localparam int MAX_PKT_LEN = 255;

  typedef enum logic {SM_HEADER, SM_DATA} len_tx_state_t;
endpackage

// File: rtl/simple_length_header_inserter_if.sv
// AXI-Stream style handshake bundle (no tkeep/tuser).
//   master: drives tvalid/tlast/tdata, receives tready
//   slave : receives tvalid/tlast/tdata, drives tready
interface simple_length_header_inserter_if #(parameter int DATA_W = 8);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, tlast, tdata, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/simple_length_header_inserter_fifo.sv
// Synchronous show-ahead FIFO: rdata always shows the head entry.
//   clk, sresetn  clock, synchronous active-low reset (empties the FIFO)
//   push, wdata   write port; caller must not push when full
//   pop           consume head; caller must not pop when empty
//   rdata         head entry, valid while !empty
//   full, afull   occupancy == DEPTH, occupancy >= DEPTH-1
//   empty         occupancy == 0
module simple_axis_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             sresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             afull,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AF = DEPTH - 1;
  localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_CNT = AF[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (cnt_q == FULL_CNT);
  assign afull = (cnt_q >= AFULL_CNT);
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/simple_length_header_inserter.sv
// Store-and-forward framer: each tlast-delimited input packet is re-emitted
// as a one-byte length header followed by its payload. Packets longer than
// MAX_PKT_LEN are cut into MAX_PKT_LEN-beat segments plus a remainder.
//   clk, sresetn  clock, synchronous active-low reset
//   axis_i        input stream (tlast framed)
//   axis_o        output stream: header beat (tlast=0) then N payload beats,
//                 tlast on the last payload beat
module simple_length_header_inserter
  import simple_length_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int BUF_DEPTH      = 256,
  parameter int LEN_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           sresetn,
  simple_length_header_inserter_if.slave  axis_i,
  simple_length_header_inserter_if.master axis_o
);
  localparam int DW    = AXIS_BYTES * 8;
  localparam int LEN_W = COUNT_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

  logic             rdy_q;
  logic [LEN_W-1:0] in_cnt_q, in_cnt_d, cnt_inc;
  logic             len_push_q, len_push_d;
  logic [LEN_W-1:0] len_val_q, len_val_d;
  len_tx_state_t    state_q, state_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;

  logic             in_acc;
  logic             buf_full, buf_empty, buf_pop, buf_afull_unused;
  logic [DW-1:0]    buf_head;
  logic             len_full, len_afull, len_empty, len_pop;
  logic [LEN_W-1:0] len_head;
  logic             o_vld, o_last;
  logic [DW-1:0]    o_data;

  // The length push lands one cycle late, so a pending push must count
  // against the length FIFO space; rdy_q holds tready low for the first
  // cycle out of reset.
  assign axis_i.tready = rdy_q && !buf_full && !len_full && !(len_push_q && len_afull);
  assign in_acc        = axis_i.tvalid && axis_i.tready;

  always_comb begin
    in_cnt_d   = in_cnt_q;
    len_push_d = 1'b0;
    len_val_d  = len_val_q;
    cnt_inc    = in_cnt_q + 1'b1;
    if (in_acc) begin
      if (axis_i.tlast || cnt_inc == MAX_LEN) begin
        len_push_d = 1'b1;
        len_val_d  = cnt_inc;
        in_cnt_d   = '0;
      end else begin
        in_cnt_d = cnt_inc;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    len_pop   = 1'b0;
    buf_pop   = 1'b0;
    o_vld     = 1'b0;
    o_last    = 1'b0;
    o_data    = '0;
    case (state_q)
      SM_HEADER: begin
        o_vld = !len_empty;
        if (o_vld) o_data = DW'(len_head);
        if (o_vld && axis_o.tready) begin
          len_pop   = 1'b1;
          out_cnt_d = len_head;
          state_d   = SM_DATA;
        end
      end
      SM_DATA: begin
        // out_cnt guarantees only committed beats are read from the buffer.
        o_vld  = !buf_empty;
        o_last = o_vld && (out_cnt_q == LEN_W'(1));
        if (o_vld) o_data = buf_head;
        if (o_vld && axis_o.tready) begin
          buf_pop   = 1'b1;
          out_cnt_d = out_cnt_q - 1'b1;
          if (out_cnt_q == LEN_W'(1)) state_d = SM_HEADER;
        end
      end
      default: state_d = SM_HEADER;
    endcase
  end

  assign axis_o.tvalid = o_vld;
  assign axis_o.tlast  = o_last;
  assign axis_o.tdata  = o_data;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      rdy_q      <= 1'b0;
      in_cnt_q   <= '0;
      len_push_q <= 1'b0;
      len_val_q  <= '0;
      state_q    <= SM_HEADER;
      out_cnt_q  <= '0;
    end else begin
      rdy_q      <= 1'b1;
      in_cnt_q   <= in_cnt_d;
      len_push_q <= len_push_d;
      len_val_q  <= len_val_d;
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  simple_axis_fifo #(.WIDTH(DW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .sresetn (sresetn),
    .push    (in_acc),
    .wdata   (axis_i.tdata),
    .pop     (buf_pop),
    .rdata   (buf_head),
    .full    (buf_full),
    .afull   (buf_afull_unused),
    .empty   (buf_empty)
  );

  simple_axis_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_FIFO_DEPTH)) u_len (
    .clk     (clk),
    .sresetn (sresetn),
    .push    (len_push_q),
    .wdata   (len_val_q),
    .pop     (len_pop),
    .rdata   (len_head),
    .full    (len_full),
    .afull   (len_afull),
    .empty   (len_empty)
  );
endmodule
